// File: rtl/fwd_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// fwd_hazard_scoreboard
// Forwarding-select and load-use hazard unit for an NPORTS-read-port pipeline.
// Tracks a shadow copy of the NSTAGES stages after decode (EX .. WB). For each
// decoded instruction it computes one bypass select per source port, and that
// select is registered so it lines up with the instruction's EX cycle. A
// combinational stall is raised while a load result is too young to forward.
// A saturating counter records the number of stall cycles.
// -----------------------------------------------------------------------------
module fwd_hazard_scoreboard #(
    parameter int RW       = 5,
    parameter int ZERO_REG = 31,
    parameter int NPORTS   = 2,
    parameter int NSTAGES  = 3,
    parameter int LOAD_RDY = 2,
    parameter int CNT_W    = 16
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  id_valid,
    input  logic [RW-1:0]                         id_rd,
    input  logic                                  id_rw,
    input  logic                                  id_is_load,
    input  logic [NPORTS*RW-1:0]                  id_rs,
    input  logic [NPORTS-1:0]                     id_rs_used,
    input  logic                                  hold_i,
    input  logic                                  flush_i,
    output logic                                  stall_o,
    output logic [NPORTS*$clog2(NSTAGES)-1:0]     fwd_sel,
    output logic [CNT_W-1:0]                      stall_cnt
);

    localparam int            SEL_W = $clog2(NSTAGES);
    localparam logic [RW-1:0] ZR    = RW'(ZERO_REG);

    // Shadow pipeline: index 0 = EX, NSTAGES-1 = WB.
    // Only the valid bits are reset; the payload is qualified by r_vld.
    logic [NSTAGES-1:0]        r_vld;
    logic [RW-1:0]             r_rd [NSTAGES];
    logic [NSTAGES-1:0]        r_rw;
    logic [NSTAGES-1:0]        r_ld;

    logic [NPORTS*SEL_W-1:0]   r_fwd_sel;
    logic [CNT_W-1:0]          r_stall_cnt;

    logic [NPORTS*SEL_W-1:0]   w_sel_all;
    logic [NPORTS-1:0]         w_early_all;
    logic                      w_stall;
    logic                      w_ins_rw;

    for (genvar p = 0; p < NPORTS; p++) begin : g_port
        logic [RW-1:0]    w_rs;
        logic [SEL_W-1:0] w_sel;
        logic             w_early;

        assign w_rs = id_rs[p*RW +: RW];

        // Youngest-match search: walk from the oldest forwardable stage down
        // to EX so the lowest matching index is the one that sticks. The WB
        // entry is excluded because the register file writes before it reads.
        always_comb begin
            w_sel   = '0;
            w_early = 1'b0;
            for (int j = NSTAGES-2; j >= 0; j--) begin
                if (id_rs_used[p] && (w_rs != ZR) &&
                    r_vld[j] && r_rw[j] && (r_rd[j] == w_rs)) begin
                    // Producer moves one stage on with the consumer, hence j+1.
                    w_sel   = SEL_W'(j + 1);
                    w_early = r_ld[j] && ((j + 1) < LOAD_RDY);
                end
            end
        end

        assign w_sel_all[p*SEL_W +: SEL_W] = w_sel;
        assign w_early_all[p]              = w_early;
    end

    assign w_stall   = id_valid && !flush_i && (|w_early_all);
    assign w_ins_rw  = id_rw && (id_rd != ZR);

    assign stall_o   = w_stall;
    assign fwd_sel   = r_fwd_sel;
    assign stall_cnt = r_stall_cnt;

    // Control state: entry valids, registered selects and the stall counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld       <= '0;
            r_fwd_sel   <= '0;
            r_stall_cnt <= '0;
        end else if (!hold_i) begin
            for (int j = NSTAGES-1; j > 0; j--) begin
                r_vld[j] <= r_vld[j-1];
            end
            if (flush_i || w_stall) begin
                // Bubble into EX; flush takes precedence over the stall.
                r_vld[0]  <= 1'b0;
                r_fwd_sel <= '0;
            end else begin
                r_vld[0]  <= id_valid;
                r_fwd_sel <= id_valid ? w_sel_all : '0;
            end
            if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    // Payload shift: destination, write-enable and load flag follow the valids.
    always_ff @(posedge clk) begin
        if (!hold_i) begin
            for (int j = NSTAGES-1; j > 0; j--) begin
                r_rd[j] <= r_rd[j-1];
                r_rw[j] <= r_rw[j-1];
                r_ld[j] <= r_ld[j-1];
            end
            r_rd[0] <= id_rd;
            r_rw[0] <= w_ins_rw;
            r_ld[0] <= id_is_load;
        end
    end

endmodule
